// File: rtl/mult_div_pkg.sv
// Shared types for the iterative multiply/divide unit: operation select and FSM state encodings.
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake and operand/result bus between the control FSM and the mult/div unit.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   import mult_div_pkg::*;

   logic             start;
   md_op_t           op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);

endinterface

// File: rtl/mult_div_unit.sv
// Shared sequential multiply (shift-add) / divide (restoring) unit producing HI/LO.
// Signed ops run on magnitudes; the result signs are applied in the FIX cycle.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           i_clock,
   input  logic           i_reset,
   mult_div_unit_if.slave md
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int DW    = 2 * WIDTH;

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x, input logic en,
                                              input logic cin);
      f_neg = en ? (~x + {{(WIDTH-1){1'b0}}, cin}) : x;
   endfunction

   md_state_t        r_state, w_state_nxt;
   md_op_t           r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [DW-1:0]    r_acc;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_opnd, r_hi, r_lo;
   logic             r_neg_res, r_neg_rem, r_div_zero;

   logic             w_accept, w_signed, w_div_in, w_b_zero, w_r_div, w_last;
   logic             w_restore, w_busy, w_done;
   logic [WIDTH-1:0] w_a_abs, w_b_abs, w_lo_fix, w_hi_fix, w_prod_hi, w_rem_fix;
   logic [WIDTH:0]   w_mul_sum, w_shift, w_diff;
   logic [DW-1:0]    w_mul_nxt;

   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && md.start;
   assign w_signed = (md.op == OP_MULT) || (md.op == OP_DIV);
   assign w_div_in = (md.op == OP_DIV) || (md.op == OP_DIVU);
   assign w_b_zero = (md.b == {WIDTH{1'b0}});
   assign w_a_abs  = f_neg(md.a, w_signed & md.a[WIDTH-1], 1'b1);
   assign w_b_abs  = f_neg(md.b, w_signed & md.b[WIDTH-1], 1'b1);
   assign w_r_div  = (r_op == OP_DIV) || (r_op == OP_DIVU);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   assign w_mul_sum = {1'b0, r_acc[DW-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Trial subtract in WIDTH+1 bits; the sign of the difference decides the restore.
   assign w_shift   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, r_opnd};
   assign w_restore = w_diff[WIDTH] & ~r_rem[WIDTH];

   // The quotient and the product low half share the low accumulator word and its sign flag.
   assign w_lo_fix  = f_neg(r_acc[WIDTH-1:0], r_neg_res, 1'b1);
   assign w_prod_hi = f_neg(r_acc[DW-1:WIDTH], r_neg_res, (r_acc[WIDTH-1:0] == {WIDTH{1'b0}}));
   assign w_rem_fix = f_neg(r_rem[WIDTH-1:0], r_neg_rem, 1'b1);
   assign w_hi_fix  = w_r_div ? w_rem_fix : w_prod_hi;

   // State register
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (md.start) begin
               w_state_nxt = (w_div_in && w_b_zero) ? S_DONE : S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_FIX;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_FIX:   w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_RUN, S_FIX: w_busy = 1'b1;
         S_DONE:       w_done = 1'b1;
         default: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   // Operand capture, iteration datapath, counter and result registers
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_op       <= OP_MULT;
         r_cnt      <= {CNT_W{1'b0}};
         r_acc      <= {DW{1'b0}};
         r_rem      <= {(WIDTH+1){1'b0}};
         r_opnd     <= {WIDTH{1'b0}};
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= {WIDTH{1'b0}};
         r_lo       <= {WIDTH{1'b0}};
      end else if (w_accept) begin
         r_op       <= md.op;
         r_cnt      <= {CNT_W{1'b0}};
         r_acc      <= {{WIDTH{1'b0}}, (w_div_in ? w_a_abs : w_b_abs)};
         r_opnd     <= w_div_in ? w_b_abs : w_a_abs;
         r_rem      <= {(WIDTH+1){1'b0}};
         r_neg_res  <= w_signed & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
         r_neg_rem  <= w_signed & md.a[WIDTH-1];
         r_div_zero <= w_div_in & w_b_zero;
      end else begin
         r_div_zero <= 1'b0;
         case (r_state)
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_r_div) begin
                  r_rem             <= w_restore ? w_shift : w_diff;
                  r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], ~w_restore};
               end else begin
                  r_acc <= w_mul_nxt;
               end
            end
            S_FIX: begin
               r_hi <= w_hi_fix;
               r_lo <= w_lo_fix;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign md.busy     = w_busy;
   assign md.done     = w_done;
   assign md.div_zero = r_div_zero;
   assign md.hi       = r_hi;
   assign md.lo       = r_lo;

endmodule
